// File: rtl/pass_entry.sv
// Keypad front end for the password lock: gathers four hex digits into `password`
// and raises confirmPass/changePass for PULSE_LEN cycles. Optional idle timeout: ENTRY_TIMEOUT_EN.
module pass_entry #(
  parameter int unsigned PULSE_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMR_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyValid,
  input  logic [3:0]  keyCode,
  output logic [15:0] password,
  output logic [2:0]  digitCount,
  output logic        confirmPass,
  output logic        changePass,
  output logic        busy,
  output logic        entryError,
  output logic        timeoutFlag
);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, SEND} state_t;

  state_t      state, state_n;
  logic [15:0] pw, pw_n;
  logic [2:0]  cnt, cnt_n;
  logic        cmd_chg, cmd_chg_n;
  logic [7:0]  pcnt, pcnt_n;
  logic        err_q, err_n;
  logic        tflag_q, tflag_n;
`ifdef ENTRY_TIMEOUT_EN
  logic [TMR_W-1:0] tmr, tmr_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pw      <= '0;
      cnt     <= '0;
      cmd_chg <= 1'b0;
      pcnt    <= '0;
      err_q   <= 1'b0;
      tflag_q <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmr     <= '0;
`endif
    end else begin
      state   <= state_n;
      pw      <= pw_n;
      cnt     <= cnt_n;
      cmd_chg <= cmd_chg_n;
      pcnt    <= pcnt_n;
      err_q   <= err_n;
      tflag_q <= tflag_n;
`ifdef ENTRY_TIMEOUT_EN
      tmr     <= tmr_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    pw_n      = pw;
    cnt_n     = cnt;
    cmd_chg_n = cmd_chg;
    pcnt_n    = pcnt;
    err_n     = 1'b0;
    tflag_n   = 1'b0;
    if (state == SEND) begin
      // password is left intact on exit; only the next digit key discards it
      if (pcnt == 8'(PULSE_LEN - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
        pcnt_n  = '0;
      end else begin
        pcnt_n = pcnt + 8'd1;
      end
    end else if (keyValid) begin
      if (keyCode <= 4'd9) begin
        case (state)
          IDLE: begin
            pw_n    = {12'h000, keyCode};
            cnt_n   = 3'd1;
            state_n = ENTRY;
          end
          ENTRY: begin
            pw_n  = {pw[11:0], keyCode};
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd3) state_n = FULL;
          end
          default: err_n = 1'b1;
        endcase
      end else begin
        case (keyCode)
          4'hA, 4'hB: begin
            if (state == FULL) begin
              state_n   = SEND;
              cmd_chg_n = (keyCode == 4'hB);
              pcnt_n    = '0;
            end else begin
              err_n = 1'b1;
            end
          end
          4'hC: begin
            state_n = IDLE;
            pw_n    = '0;
            cnt_n   = '0;
          end
          4'hD: begin
            if (cnt != 3'd0) begin
              pw_n    = {4'h0, pw[15:4]};
              cnt_n   = cnt - 3'd1;
              state_n = (cnt == 3'd1) ? IDLE : ENTRY;
            end
          end
          default: err_n = 1'b1;
        endcase
      end
    end
`ifdef ENTRY_TIMEOUT_EN
    // a key on the expiry cycle wins: it is processed above and restarts the timer
    tmr_n = tmr;
    if (state != SEND && keyValid) begin
      tmr_n = '0;
    end else if (state == ENTRY || state == FULL) begin
      if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        tmr_n   = '0;
        state_n = IDLE;
        pw_n    = '0;
        cnt_n   = '0;
        tflag_n = 1'b1;
      end else begin
        tmr_n = tmr + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    busy        = (state == SEND);
    confirmPass = busy && !cmd_chg;
    changePass  = busy && cmd_chg;
    password    = pw;
    digitCount  = cnt;
    entryError  = err_q;
`ifdef ENTRY_TIMEOUT_EN
    timeoutFlag = tflag_q;
`else
    // constant 0; the timer parameters are referenced so both builds share one parameter list
    timeoutFlag = tflag_q && (TIMEOUT_CYCLES == 0) && (TMR_W == 0);
`endif
  end

endmodule

// File: tb/tb_pass_entry.sv
// Directed bench for pass_entry: digit entry, commands, errors, SEND behaviour, reset and timeout.
module tb_pass_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] password;
  logic [2:0]  digitCount;
  logic        confirmPass, changePass, busy, entryError, timeoutFlag;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  pass_entry #(.PULSE_LEN(4), .TIMEOUT_CYCLES(20), .TMR_W(20)) dut (
    .clk(clk), .rst(rst), .keyValid(keyValid), .keyCode(keyCode),
    .password(password), .digitCount(digitCount), .confirmPass(confirmPass),
    .changePass(changePass), .busy(busy), .entryError(entryError),
    .timeoutFlag(timeoutFlag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one strobe; returns at the negedge after the sampling edge
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    keyValid = 1'b1;
    keyCode  = k;
    @(negedge clk);
    keyValid = 1'b0;
  endtask

  // count consecutive high cycles of the selected command starting now
  task automatic measure(input bit chg, input bit poke, output int unsigned hi,
                         output bit busy_ok, output bit other_low, output bit no_err);
    hi = 0; busy_ok = 1'b1; other_low = 1'b1; no_err = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(chg ? changePass : confirmPass)) break;
      hi++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ((chg ? confirmPass : changePass) !== 1'b0) other_low = 1'b0;
      if (entryError !== 1'b0) no_err = 1'b0;
      keyValid = poke && (i == 0);
      keyCode  = 4'h5;
      @(negedge clk);
      keyValid = 1'b0;
    end
  endtask

  initial begin
    int unsigned hi;
    bit busy_ok, other_low, no_err;
    rst = 1'b1; keyValid = 1'b0; keyCode = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_pw", password, 16'h0000);
    check("reset_cnt", digitCount, 3'd0);
    check("reset_outs", {confirmPass, changePass, busy, entryError, timeoutFlag}, 5'b0);

    press(4'h4); press(4'h7); press(4'h8); press(4'h1);
    check("full_pw", password, 16'h4781);
    check("full_cnt", digitCount, 3'd4);
    press(4'hA);
    measure(1'b0, 1'b0, hi, busy_ok, other_low, no_err);
    check("confirm_len", hi, 4);
    check("confirm_busy", busy_ok, 1'b1);
    check("confirm_nochg", other_low, 1'b1);
    check("post_send_cnt", digitCount, 3'd0);
    check("post_send_pw", password, 16'h4781);
    check("post_send_busy", busy, 1'b0);

    press(4'h4); press(4'h0); press(4'h1); press(4'h2);
    check("chg_pw", password, 16'h4012);
    press(4'hB);
    measure(1'b1, 1'b1, hi, busy_ok, other_low, no_err);
    check("change_len", hi, 4);
    check("change_noconf", other_low, 1'b1);
    check("send_key_noerr", no_err, 1'b1);
    check("send_key_pw", password, 16'h4012);
    check("send_key_cnt", digitCount, 3'd0);

    press(4'h1); press(4'h2); press(4'hA);
    check("early_enter_err", entryError, 1'b1);
    check("early_enter_cnt", digitCount, 3'd2);
    @(negedge clk);
    check("err_one_cycle", entryError, 1'b0);
    press(4'hD);
    check("bksp_pw", password, 16'h0001);
    check("bksp_cnt", digitCount, 3'd1);
    check("bksp_noerr", entryError, 1'b0);
    press(4'hC);
    check("clear_pw", password, 16'h0000);
    check("clear_cnt", digitCount, 3'd0);
    press(4'hD);
    check("bksp_empty_noerr", entryError, 1'b0);

    press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'h3);
    check("fifth_err", entryError, 1'b1);
    check("fifth_pw", password, 16'h9999);
    check("fifth_cnt", digitCount, 3'd4);
    press(4'hC); press(4'hF);
    check("illegal_err", entryError, 1'b1);
    check("illegal_cnt", digitCount, 3'd0);

`ifdef ENTRY_TIMEOUT_EN
    press(4'h6);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hi++;
      if (timeoutFlag) break;
    end
    check("timeout_delay", hi, 20);
    check("timeout_flag", timeoutFlag, 1'b1);
    check("timeout_pw", password, 16'h0000);
    check("timeout_cnt", digitCount, 3'd0);
    press(4'h6);
    repeat (19) @(negedge clk);
    keyValid = 1'b1; keyCode = 4'h2;
    @(negedge clk);
    keyValid = 1'b0;
    check("expiry_key_noflag", timeoutFlag, 1'b0);
    check("expiry_key_cnt", digitCount, 3'd2);
    check("expiry_key_pw", password, 16'h0062);
    press(4'hC);
`else
    press(4'h6);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (timeoutFlag) hi++;
    end
    check("no_timeout_flag", hi, 0);
    check("no_timeout_cnt", digitCount, 3'd1);
    check("no_timeout_pw", password, 16'h0006);
    press(4'hC);
`endif

    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
    check("rst_send_on", confirmPass, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_send_conf", confirmPass, 1'b0);
    check("rst_send_busy", busy, 1'b0);
    check("rst_send_pw", password, 16'h0000);
    check("rst_send_cnt", digitCount, 3'd0);
    press(4'h7);
    check("rst_idle_digit", password, 16'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pass_entry.md
Name: pass_entry

Overview:
- Keypad-side front end of the password lock. Collects four hex-coded digit keystrokes into the 16-bit `password` word consumed by the lock's compare/confirm block.
- Issues the `confirmPass` or `changePass` command level toward the lock when the user presses Enter or Change on a full entry.
- Sits between the keypad scanner, which supplies one-cycle `keyValid` strobes, and the confirm block.

Parameters:
- PULSE_LEN, 4: cycles that `confirmPass`/`changePass` are held high per command (legal range 1–255).
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted key before a partial or full entry is discarded (only with ENTRY_TIMEOUT_EN).
- TMR_W, 20: width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- keyValid, input, 1: one-cycle strobe; `keyCode` is valid in the same cycle.
- keyCode, input, 4: 0x0–0x9 digit, 0xA Enter, 0xB Change, 0xC Clear, 0xD Backspace, 0xE/0xF illegal.
- password, output, 16: assembled entry; first digit ends in [15:12], last digit in [3:0].
- digitCount, output, 3: digits currently held, 0–4.
- confirmPass, output, 1: held high for PULSE_LEN cycles on an Enter command.
- changePass, output, 1: held high for PULSE_LEN cycles on a Change command.
- busy, output, 1: high while in SEND.
- entryError, output, 1: one-cycle pulse on a rejected key.
- timeoutFlag, output, 1: one-cycle pulse when an entry is discarded by timeout.

Behaviour:
- Reset: state IDLE; `password` = 16'h0000; `digitCount` = 0; `confirmPass`, `changePass`, `busy`, `entryError` and `timeoutFlag` = 0; timer = 0. A reset during SEND drops any command level on the next edge.
- States:
  - IDLE: count 0, or a completed entry being retained.
  - ENTRY: 1–3 digits held.
  - FULL: 4 digits held.
  - SEND: command level active.
- Key handling is evaluated only on cycles where `keyValid`=1. All output effects are registered and appear one cycle after the strobe.
- Digit key:
  - In IDLE: `password` <= {12'h000, key}, count <= 1, go to ENTRY. Any previously retained entry is discarded.
  - In ENTRY: `password` <= {password[11:0], key}, count+1. When count reaches 4, go to FULL.
  - In FULL: key ignored, `entryError` pulses, nothing else changes.
- Enter (0xA):
  - In FULL: go to SEND with `confirmPass`=1.
  - In IDLE or ENTRY: `entryError` pulses, no state change.
- Change (0xB): same rules as Enter, but drives `changePass`.
- Clear (0xC): from IDLE, ENTRY or FULL, go to IDLE with `password`=0 and count=0. Never raises `entryError`.
- Backspace (0xD):
  - count > 0: `password` <= {4'h0, password[15:4]}, count-1. Go to IDLE if count becomes 0, otherwise to ENTRY.
  - count = 0: ignored, no error.
- Keys 0xE/0xF: `entryError` pulses in any state except SEND.
- SEND:
  - The command output is high for exactly PULSE_LEN consecutive cycles; `busy` is high for the same cycles.
  - `password` and `digitCount` stay stable throughout.
  - All keys are ignored, with no error pulse.
  - On exit, go to IDLE with count=0, but `password` retains its value until the next digit key.
- `confirmPass` and `changePass` are never high simultaneously.

Optional Feature:
- Macro ENTRY_TIMEOUT_EN.
- When defined:
  - The timer clears on every accepted key and counts every cycle in ENTRY or FULL.
  - When the timer reaches TIMEOUT_CYCLES-1 with no key: go to IDLE, `password`=0, count=0, and `timeoutFlag` pulses for one cycle.
  - If a key strobe arrives in the same cycle as expiry, the key is processed and the timer restarts; no timeout occurs.
  - The timer is frozen in IDLE and SEND.
- When undefined: no timer logic exists, `timeoutFlag` is tied to 0, and an entry persists indefinitely.

Test Plan:
- Reset, then keys 4,7,8,1,A → after the 4th digit `password`=16'h4781 and `digitCount`=4. `confirmPass` is high for exactly 4 cycles starting one cycle after A, `busy` matches it, `changePass` stays 0, then state returns to IDLE with `password` still 16'h4781.
- Keys 4,0,1,2,B → `password`=16'h4012 and `changePass` pulses for 4 cycles. Key 5 pressed during SEND is ignored: no error, `password` unchanged.
- Keys 1,2,A → `entryError` pulses once, `digitCount` stays 2. Then D → `password`=16'h0001, count 1. Then C → `password`=0, count 0.
- Keys 9,9,9,9 then 3 → fifth digit rejected with an `entryError` pulse and `password` stays 16'h9999. Key F in IDLE → `entryError` pulses.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20: key 6, then idle → `timeoutFlag` pulses and `password`=0.
  - Repeat with key 6, then a digit key on the expiry cycle → no timeout, count=2.
- `rst` asserted on the 2nd cycle of SEND → on the next edge `confirmPass`=0, `password`=0, state IDLE.
